// File: rtl/retro_cart_responder.sv
// Cartridge-side target: serves cache line fills and writebacks from slow
// backing memory, with a one-entry sequential read-ahead buffer.
module retro_cart_responder #(
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1,
  parameter int CacheLineBits   = 7,
  parameter int TimeoutCycles   = 255
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         TgtAccess,
  input  logic                         TgtWrite,
  input  logic [AddressBusWidth-1:0]   TgtAddress,
  input  logic [DataBusWidth*8-1:0]    TgtDin,
  output logic [DataBusWidth*8-1:0]    TgtDout,
  output logic                         TgtReady,
  output logic                         MemReq,
  output logic                         MemWrite,
  output logic [AddressBusWidth-1:0]   MemAddress,
  output logic [DataBusWidth*8-1:0]    MemWData,
  input  logic [DataBusWidth*8-1:0]    MemRData,
  input  logic                         MemAck,
  output logic                         Error
);

  localparam int AW = AddressBusWidth;
  localparam int DW = DataBusWidth * 8;
  localparam int CW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND,
    PREFETCH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0] req_addr;
  logic          req_write;
  logic          pf_valid;
  logic [AW-1:0] pf_addr;
  logic [DW-1:0] pf_data;
  logic          pf_kill;
  logic [CW-1:0] wait_cnt;

  logic          pf_hit;
  logic          pf_wr_hit;
  logic          last_line;
  logic          timeout;
  logic [AW-1:0] next_addr;

  assign pf_hit    = pf_valid && !TgtWrite && (TgtAddress == pf_addr);
  assign pf_wr_hit = TgtAccess && TgtWrite && (TgtAddress == pf_addr);
  assign last_line = &req_addr[CacheLineBits-1:0];
  assign next_addr = req_addr + AW'(1);
  assign timeout   = MemReq && !MemAck &&
                     (wait_cnt == CW'(TimeoutCycles - 1));

  assign TgtReady = (state == RESPOND);
  assign MemReq   = (state == ISSUE) || (state == PREFETCH);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (TgtAccess) begin
          state_nxt = pf_hit ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        if (MemAck || timeout) begin
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        state_nxt = (!req_write && !last_line) ? PREFETCH : IDLE;
      end
      PREFETCH: begin
        if (MemAck || timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter: cycles of an outstanding memory request without ack.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (MemReq && !MemAck) begin
      if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      TgtDout    <= '0;
      MemWrite   <= 1'b0;
      MemAddress <= '0;
      MemWData   <= '0;
      req_addr   <= '0;
      req_write  <= 1'b0;
      pf_valid   <= 1'b0;
      pf_addr    <= '0;
      pf_data    <= '0;
      pf_kill    <= 1'b0;
      Error      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (TgtAccess) begin
            req_addr  <= TgtAddress;
            req_write <= TgtWrite;
            if (pf_wr_hit) begin
              pf_valid <= 1'b0;
            end
            if (pf_hit) begin
              TgtDout <= pf_data;
            end else begin
              MemAddress <= TgtAddress;
              MemWrite   <= TgtWrite;
              MemWData   <= TgtDin;
            end
          end
        end
        ISSUE: begin
          if (MemAck) begin
            if (!req_write) begin
              TgtDout <= MemRData;
            end
          end else if (timeout) begin
            TgtDout <= '1;
            Error   <= 1'b1;
          end
        end
        RESPOND: begin
          // Any read retires the old buffer; a new line-internal
          // read-ahead refills it.
          if (!req_write) begin
            pf_valid <= 1'b0;
            if (!last_line) begin
              pf_addr    <= next_addr;
              pf_kill    <= 1'b0;
              MemAddress <= next_addr;
              MemWrite   <= 1'b0;
            end
          end
        end
        PREFETCH: begin
          if (pf_wr_hit) begin
            pf_kill <= 1'b1;
          end
          if (MemAck) begin
            pf_data  <= MemRData;
            pf_valid <= !(pf_kill || pf_wr_hit);
          end else if (timeout) begin
            pf_valid <= 1'b0;
            Error    <= 1'b1;
          end
        end
        default: begin
          pf_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retro_cart_responder.sv
// Directed bench for retro_cart_responder: vector table plus hand-written
// sequences for latency, prefetch, timeout and reset corners.
module tb_retro_cart_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        TgtAccess = 1'b0;
  logic        TgtWrite = 1'b0;
  logic [15:0] TgtAddress = '0;
  logic [7:0]  TgtDin = '0;
  logic [7:0]  TgtDout;
  logic        TgtReady;
  logic        MemReq;
  logic        MemWrite;
  logic [15:0] MemAddress;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;
  logic        MemAck;
  logic        Error;

  int checks = 0;
  int failures = 0;

  int lat = 1;
  bit mem_on = 1'b1;
  bit ack_force = 1'b0;
  int mcnt = 0;
  int n280 = 0;
  logic [15:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0;
  logic [7:0]  wmem [65536];
  bit          wval [65536];

  retro_cart_responder dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .TgtAccess  (TgtAccess),
    .TgtWrite   (TgtWrite),
    .TgtAddress (TgtAddress),
    .TgtDin     (TgtDin),
    .TgtDout    (TgtDout),
    .TgtReady   (TgtReady),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .MemAddress (MemAddress),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .MemAck     (MemAck),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a == 16'h0100) ? 8'h5A : (a[7:0] ^ a[15:8]);
  endfunction

  // Backing memory: ack after lat cycles of MemReq, writes stored on ack.
  assign MemRData = wval[MemAddress] ? wmem[MemAddress] : pat(MemAddress);
  assign MemAck = ack_force || (mem_on && MemReq && mcnt >= lat);

  always @(posedge Clk) begin
    mcnt <= (!MemReq || MemAck) ? 0 : mcnt + 1;
    if (MemReq && MemWrite && MemAck) begin
      wmem[MemAddress] <= MemWData;
      wval[MemAddress] <= 1'b1;
      last_waddr <= MemAddress;
      last_wdata <= MemWData;
    end
    if (MemReq && MemAddress == 16'h0280) n280 <= n280 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    TgtAccess = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic xact(input bit w, input logic [15:0] a,
                      input logic [7:0] d, output int cyc,
                      output logic [7:0] dout, output int starts,
                      output int reqc, output bit ackb);
    logic prev;
    bit ok;
    @(posedge Clk);
    #1;
    TgtAccess = 1'b1;
    TgtWrite = w;
    TgtAddress = a;
    TgtDin = d;
    prev = MemReq;
    cyc = 0;
    starts = 0;
    reqc = 0;
    ackb = 1'b0;
    ok = 1'b0;
    dout = '0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (MemReq && !prev) starts++;
      if (MemReq) reqc++;
      prev = MemReq;
      if (TgtReady) begin
        ok = 1'b1;
        dout = TgtDout;
      end else begin
        ackb = MemAck;
      end
    end
    TgtAccess = 1'b0;
    chk($sformatf("handshake %0h", a), 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  dout;
    int          cyc;
    int          starts;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, starts, reqc, n0, seen;
    logic [7:0] dout;
    bit ackb;

    // lat = 1 throughout; cycle counts hand-derived per state path
    tbl[0]  = '{1'b0, 16'h0300, 8'h00, 8'h03, 3, 1};
    tbl[1]  = '{1'b0, 16'h0301, 8'h00, 8'h02, 3, 0};
    tbl[2]  = '{1'b0, 16'h0310, 8'h00, 8'h13, 5, 1};
    tbl[3]  = '{1'b1, 16'h0311, 8'h77, 8'h13, 5, 1};
    tbl[4]  = '{1'b0, 16'h0311, 8'h00, 8'h77, 3, 1};
    tbl[5]  = '{1'b1, 16'h0400, 8'h44, 8'h77, 5, 1};
    tbl[6]  = '{1'b0, 16'h0312, 8'h00, 8'h11, 1, 0};
    tbl[7]  = '{1'b0, 16'h0400, 8'h00, 8'h44, 5, 1};
    tbl[8]  = '{1'b0, 16'h047F, 8'h00, 8'h7B, 5, 1};
    tbl[9]  = '{1'b0, 16'h0401, 8'h00, 8'h05, 3, 1};
    tbl[10] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 5, 1};
    tbl[11] = '{1'b0, 16'hFFFE, 8'h00, 8'h01, 3, 1};
    tbl[12] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 3, 0};

    // Reset values
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst TgtReady", 32'(TgtReady), 32'd0);
    chk("rst MemReq", 32'(MemReq), 32'd0);
    chk("rst MemWrite", 32'(MemWrite), 32'd0);
    chk("rst MemAddress", 32'(MemAddress), 32'd0);
    chk("rst MemWData", 32'(MemWData), 32'd0);
    chk("rst TgtDout", 32'(TgtDout), 32'd0);
    chk("rst Error", 32'(Error), 32'd0);

    // Miss with 3-cycle memory, then read-ahead of the next byte
    lat = 3;
    do_reset();
    xact(1'b0, 16'h0100, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("miss latency", 32'(cyc), 32'd5);
    chk("miss dout", 32'(dout), 32'h5A);
    chk("ack before ready", 32'(ackb), 32'd1);
    @(posedge Clk);
    #1;
    chk("ready one cycle", 32'(TgtReady), 32'd0);
    chk("pf MemReq", 32'(MemReq), 32'd1);
    chk("pf MemWrite", 32'(MemWrite), 32'd0);
    chk("pf MemAddress", 32'(MemAddress), 32'h0101);

    // Vector table
    lat = 1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      xact(tbl[i].w, tbl[i].a, tbl[i].d, cyc, dout, starts, reqc, ackb);
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(tbl[i].dout));
      chk($sformatf("vec%0d cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("vec%0d mem starts", i), 32'(starts),
          32'(tbl[i].starts));
    end

    // Write hits in-flight read-ahead address
    lat = 1;
    do_reset();
    xact(1'b0, 16'h0100, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("kill rd dout", 32'(dout), 32'h5A);
    xact(1'b1, 16'h0101, 8'h33, cyc, dout, starts, reqc, ackb);
    chk("kill wr addr", 32'(last_waddr), 32'h0101);
    chk("kill wr data", 32'(last_wdata), 32'h33);
    xact(1'b0, 16'h0101, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("kill reread starts", 32'(starts), 32'd1);
    chk("kill reread dout", 32'(dout), 32'h33);

    // 128 sequential reads across one line, 2-cycle memory
    lat = 2;
    do_reset();
    n0 = n280;
    for (int i = 0; i < 128; i++) begin
      xact(1'b0, 16'h0200 + 16'(i), 8'h00, cyc, dout, starts, reqc, ackb);
      chk($sformatf("seq%0d dout", i), 32'(dout),
          32'(pat(16'h0200 + 16'(i))));
      chk($sformatf("seq%0d starts", i), 32'(starts), (i == 0) ? 1 : 0);
      chk($sformatf("seq%0d cycles", i), 32'(cyc), 32'd4);
    end
    repeat (10) @(posedge Clk);
    #1;
    chk("no req to 0x0280", 32'(n280 - n0), 32'd0);
    chk("seq end MemReq", 32'(MemReq), 32'd0);

    // Demand timeout, memory never acks
    lat = 1;
    do_reset();
    mem_on = 1'b0;
    xact(1'b0, 16'h0500, 8'h00, cyc, dout, starts, reqc, ackb);
    mem_on = 1'b1;
    chk("tmo cycles", 32'(cyc), 32'd256);
    chk("tmo req cycles", 32'(reqc), 32'd255);
    chk("tmo dout", 32'(dout), 32'hFF);
    chk("tmo MemReq", 32'(MemReq), 32'd0);
    chk("tmo Error", 32'(Error), 32'd1);
    xact(1'b0, 16'h0600, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("post tmo dout", 32'(dout), 32'h06);
    chk("post tmo cycles", 32'(cyc), 32'd5);
    chk("Error sticky", 32'(Error), 32'd1);

    // Read-ahead timeout drops the buffer
    xact(1'b0, 16'h0710, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("pf tmo rd dout", 32'(dout), 32'h17);
    mem_on = 1'b0;
    repeat (300) @(posedge Clk);
    mem_on = 1'b1;
    xact(1'b0, 16'h0711, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("pf tmo miss starts", 32'(starts), 32'd1);
    chk("pf tmo miss cycles", 32'(cyc), 32'd3);
    chk("pf tmo miss dout", 32'(dout), 32'h16);

    // Reset during ISSUE, stray ack afterwards
    repeat (5) @(posedge Clk);
    mem_on = 1'b0;
    @(posedge Clk);
    #1;
    TgtAccess = 1'b1;
    TgtWrite = 1'b0;
    TgtAddress = 16'h0800;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("rst mid MemReq before", 32'(MemReq), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst mid TgtReady", 32'(TgtReady), 32'd0);
    chk("rst mid MemReq", 32'(MemReq), 32'd0);
    chk("rst mid MemWrite", 32'(MemWrite), 32'd0);
    chk("rst mid MemAddress", 32'(MemAddress), 32'd0);
    chk("rst mid MemWData", 32'(MemWData), 32'd0);
    chk("rst mid TgtDout", 32'(TgtDout), 32'd0);
    chk("rst mid Error", 32'(Error), 32'd0);
    TgtAccess = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    ack_force = 1'b1;
    @(negedge Clk);
    ack_force = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge Clk);
      #1;
      if (TgtReady || MemReq) seen++;
    end
    chk("late ack ignored", 32'(seen), 32'd0);
    mem_on = 1'b1;
    xact(1'b0, 16'h0905, 8'h00, cyc, dout, starts, reqc, ackb);
    chk("after rst cycles", 32'(cyc), 32'd3);
    chk("after rst dout", 32'(dout), 32'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
